// File: rtl/yarp_pc_gen.sv
// Fetch program-counter generator: sequential advance, branch/jump redirects,
// trap vectoring and redirects deferred across data-cache stalls.
module yarp_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             trap_i,
  input  logic [31:0]      trap_vec_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      next_pc_o,
  output logic             pc_valid_o,
  output logic             flush_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HOLD,
    S_PEND
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             pend_mis_q, pend_mis_d;
  logic             valid_q;
  logic             flush_q, flush_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] trap_pc;
  logic        redir_mis;

  assign trap_pc   = {trap_vec_i[31:2], 2'b00};
  assign redir_mis = (redirect_pc_i[1:0] != 2'b00);

  // Priority mux: trap > deferred redirect > live redirect > stall > advance.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_mis_d = pend_mis_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;
    cnt_d      = cnt_q;

    if (state_q == S_RUN && !stall_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_q == S_BOOT) begin
      pc_d    = RESET_PC;
      state_d = S_RUN;
    end else if (trap_i) begin
      pc_d       = trap_pc;
      flush_d    = 1'b1;
      pend_pc_d  = '0;
      pend_mis_d = 1'b0;
      state_d    = stall_i ? S_HOLD : S_RUN;
    end else if (state_q == S_PEND && !stall_i) begin
      // A misaligned target captured while stalled vectors to the trap handler.
      pc_d       = pend_mis_q ? trap_pc : pend_pc_q;
      mis_d      = pend_mis_q;
      flush_d    = 1'b1;
      pend_mis_d = 1'b0;
      state_d    = S_RUN;
    end else if (redirect_valid_i && !stall_i) begin
      pc_d    = redir_mis ? trap_pc : redirect_pc_i;
      mis_d   = redir_mis;
      flush_d = 1'b1;
      state_d = S_RUN;
    end else if (redirect_valid_i) begin
      // Youngest redirect wins if several arrive during one stall.
      pend_pc_d  = redirect_pc_i;
      pend_mis_d = redir_mis;
      state_d    = S_PEND;
    end else if (stall_i) begin
      if (state_q != S_PEND) begin
        state_d = S_HOLD;
      end
    end else begin
      pc_d    = pc_q + 32'd4;
      state_d = S_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      pend_mis_q <= 1'b0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_mis_q <= pend_mis_d;
      valid_q    <= 1'b1;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o         = pc_q;
  assign next_pc_o    = pc_d;
  assign pc_valid_o   = valid_q;
  assign flush_o      = flush_q;
  assign misaligned_o = mis_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_yarp_pc_gen.sv
// Self-checking bench for yarp_pc_gen: directed plan steps followed by random
// stimulus compared against a behavioural model of the fetch PC.
module tb_yarp_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam int          CNT_W    = 8;
  localparam int unsigned CNT_MOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             stall_i = 1'b0;
  logic             redirect_valid_i = 1'b0;
  logic [31:0]      redirect_pc_i = '0;
  logic             trap_i = 1'b0;
  logic [31:0]      trap_vec_i = '0;
  logic [31:0]      pc_o;
  logic [31:0]      next_pc_o;
  logic             pc_valid_o;
  logic             flush_o;
  logic             misaligned_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  always #5 clk = ~clk;

  yarp_pc_gen #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_i           (trap_i),
    .trap_vec_i       (trap_vec_i),
    .pc_o             (pc_o),
    .next_pc_o        (next_pc_o),
    .pc_valid_o       (pc_valid_o),
    .flush_o          (flush_o),
    .misaligned_o     (misaligned_o),
    .fetch_cnt_o      (fetch_cnt_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural PC plus flags describing where we are.
  bit          m_boot, m_pending, m_held, m_pend_mis, m_flush, m_mis;
  logic [31:0] m_pc, m_pend_pc;
  int unsigned m_cnt;
  bit          x_boot, x_pending, x_held, x_pend_mis, x_flush, x_mis;
  logic [31:0] x_pc, x_pend_pc;
  int unsigned x_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pending = 0; m_held = 0; m_pend_mis = 0;
    m_flush = 0; m_mis = 0; m_pc = RESET_PC; m_pend_pc = '0; m_cnt = 0;
  endtask

  // Work out the state after the coming edge from the current inputs.
  task automatic model_calc();
    logic [31:0] vec;
    bit          bad;
    vec = trap_vec_i & 32'hFFFF_FFFC;
    bad = (redirect_pc_i % 4) != 0;
    x_boot = m_boot; x_pending = m_pending; x_held = m_held;
    x_pend_mis = m_pend_mis; x_pend_pc = m_pend_pc; x_pc = m_pc;
    x_flush = 0; x_mis = 0; x_cnt = m_cnt;
    if (!m_boot && !m_pending && !m_held && !stall_i) x_cnt = (m_cnt + 1) % CNT_MOD;
    if (m_boot) begin
      x_boot = 0;
    end else if (trap_i) begin
      x_pc = vec; x_flush = 1; x_pending = 0; x_pend_mis = 0; x_held = stall_i;
    end else if (m_pending && !stall_i) begin
      x_pc = m_pend_mis ? vec : m_pend_pc;
      x_mis = m_pend_mis; x_flush = 1; x_pending = 0; x_pend_mis = 0; x_held = 0;
    end else if (redirect_valid_i && !stall_i) begin
      x_pc = bad ? vec : redirect_pc_i; x_mis = bad; x_flush = 1; x_held = 0;
    end else if (redirect_valid_i) begin
      x_pend_pc = redirect_pc_i; x_pend_mis = bad; x_pending = 1; x_held = 0;
    end else if (stall_i) begin
      if (!m_pending) x_held = 1;
    end else begin
      x_pc = m_pc + 32'd4; x_held = 0;
    end
  endtask

  task automatic model_commit();
    m_boot = x_boot; m_pending = x_pending; m_held = x_held;
    m_pend_mis = x_pend_mis; m_pend_pc = x_pend_pc; m_pc = x_pc;
    m_flush = x_flush; m_mis = x_mis; m_cnt = x_cnt;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"}, pc_o, m_pc);
    check({tag, ".valid"}, 32'(pc_valid_o), 32'(!m_boot));
    check({tag, ".flush"}, 32'(flush_o), 32'(m_flush));
    check({tag, ".mis"}, 32'(misaligned_o), 32'(m_mis));
    check({tag, ".cnt"}, 32'(fetch_cnt_o), m_cnt);
  endtask

  // Drive one cycle of inputs, check next_pc_o before the edge and the
  // registered outputs just after it.
  task automatic step(input string tag, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit tr, input logic [31:0] vec);
    stall_i = st; redirect_valid_i = rv; redirect_pc_i = rpc;
    trap_i = tr; trap_vec_i = vec;
    #1;
    model_calc();
    check({tag, ".next_pc"}, next_pc_o, x_pc);
    @(posedge clk);
    model_commit();
    #1;
    check_outputs(tag);
  endtask

  localparam logic [31:0] VEC = 32'h0800_0003;

  initial begin
    // Reset state while reset_n is held low.
    #12;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_outputs("boot");
    check("boot.pc_lit", pc_o, 32'h0000_1000);

    // Boot sequence then sequential fetch.
    step("run0", 0, 0, 0, 0, VEC);
    check("run0.valid_lit", 32'(pc_valid_o), 32'd1);
    step("run1", 0, 0, 0, 0, VEC);
    step("run2", 0, 0, 0, 0, VEC);
    check("run2.pc_lit", pc_o, 32'h0000_1008);
    check("run2.cnt_lit", 32'(fetch_cnt_o), 32'd2);
    step("run3", 0, 0, 0, 0, VEC);
    step("run4", 0, 0, 0, 0, VEC);
    check("run4.pc_lit", pc_o, 32'h0000_1010);

    // Unstalled redirect.
    step("redir", 0, 1, 32'h0000_2000, 0, VEC);
    check("redir.flush_lit", 32'(flush_o), 32'd1);
    step("redir_next", 0, 0, 0, 0, VEC);
    check("redir_next.pc_lit", pc_o, 32'h0000_2004);

    // Redirect arriving mid-stall is deferred until the stall drops.
    step("stall1", 1, 0, 0, 0, VEC);
    step("stall2", 1, 1, 32'h0000_3000, 0, VEC);
    step("stall3", 1, 0, 0, 0, VEC);
    step("unstall", 0, 0, 0, 0, VEC);
    check("unstall.pc_lit", pc_o, 32'h0000_3000);
    step("after_pend", 0, 0, 0, 0, VEC);

    // Trap beats a stalled redirect and discards it.
    step("trap", 1, 1, 32'h0000_5000, 1, VEC);
    check("trap.pc_lit", pc_o, 32'h0800_0000);
    step("trap_next", 0, 0, 0, 0, VEC);
    check("trap_next.pc_lit", pc_o, 32'h0800_0004);

    // Misaligned redirect, live and deferred.
    step("mis", 0, 1, 32'h0000_4002, 0, VEC);
    check("mis.mis_lit", 32'(misaligned_o), 32'd1);
    step("mis_next", 0, 0, 0, 0, VEC);
    step("dmis_cap", 1, 1, 32'h0000_4001, 0, VEC);
    step("dmis_app", 0, 0, 0, 0, VEC);

    // PC wraps modulo 2^32.
    step("wrap_set", 0, 1, 32'hFFFF_FFFC, 0, VEC);
    step("wrap", 0, 0, 0, 0, VEC);
    check("wrap.pc_lit", pc_o, 32'h0000_0000);

    // Random traffic, long enough to wrap the narrow fetch counter.
    for (int i = 0; i < 600; i++) begin
      bit          st, rv, tr;
      logic [31:0] rpc;
      st  = $urandom_range(0, 99) < 30;
      rv  = $urandom_range(0, 99) < 20;
      tr  = $urandom_range(0, 99) < 4;
      rpc = $urandom;
      if ($urandom_range(0, 9) != 0) rpc[1:0] = 2'b00;
      step("rand", st, rv, rpc, tr, $urandom);
    end

    // Async reset while a redirect is pending.
    step("pend_rst", 1, 1, 32'h0000_7000, 0, VEC);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.next_pc", next_pc_o, RESET_PC);
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    reset_n = 1'b1;
    check_outputs("reboot");
    step("reboot1", 0, 0, 0, 0, VEC);
    check("reboot1.pc_lit", pc_o, 32'h0000_1000);
    step("reboot2", 0, 0, 0, 0, VEC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
